bus_ram: RTL and testbench
==========================

BUS_RAM -- requirements
Module: bus_ram

Interface
REQ-001 Parameter ADDRVAL, default 32'hF0000000, base bus address of the slave window.
REQ-002 Parameter ADDRBITS, default 14, log2 of depth in 32-bit words (range 4..16).
REQ-003 Parameter LATENCY, default 4, cycles from request cycle to ack cycle (range 3..8).
REQ-004 Parameter ACK_WRITES, default 0; 1 = writes acknowledged like reads.
REQ-005 i_clk  input  1  sole clock; all logic rising-edge.
REQ-006 i_rst  input  1  synchronous, active-high reset.
REQ-007 i_addr  input  32  word address of the bus request.
REQ-008 i_we  input  1  write strobe, single cycle per request.
REQ-009 i_data  input  32  write data, valid with i_we.
REQ-010 i_re  input  1  read strobe, single cycle per request.
REQ-011 o_data  output  32  read data, valid only while o_ack = 1, else 32'd0.
REQ-012 o_ack  output  1  one-cycle response strobe.

Function
REQ-013 Chip select: hit = ((i_addr & ~(2^ADDRBITS-1)) == ADDRVAL); memory index = i_addr[ADDRBITS-1:0] only.
REQ-014 Misses produce no memory access and no ack; o_ack/o_data stay 0.
REQ-015 Fully pipelined: one new request accepted every cycle, no stall, no backpressure.
REQ-016 Stage 1 registers addr, data, we, re, hit; access occurs in stage 2; remaining LATENCY-2 stages are pure delay of data and ack.
REQ-017 Read hit in cycle n -> o_ack = 1 and o_data = memory word in cycle n+LATENCY exactly.
REQ-018 Write hit in cycle n commits to memory at the clock edge ending cycle n+1.
REQ-019 Write hit with ACK_WRITES = 1 -> o_ack = 1 in cycle n+LATENCY, o_data = 32'd0; with ACK_WRITES = 0 -> no ack.
REQ-020 i_we and i_re both 1 on a hit: read-first; returned data is the pre-write word, write commits, exactly one ack.
REQ-021 Back-to-back write then read to the same address (cycles n, n+1): read returns the new data.
REQ-022 Acks emerge strictly in request order, no reordering, no merging.
REQ-023 Address ADDRVAL + 2^ADDRBITS - 1 is the last valid word; ADDRVAL + 2^ADDRBITS misses (no wrap).
REQ-024 o_data is 32'd0 in every cycle where o_ack = 0; no X on outputs after reset.

Reset
REQ-025 i_rst = 1 clears all pipeline valid/ack bits and o_data, o_ack to 0 on the same edge.
REQ-026 Requests in flight at reset are dropped: no ack is ever produced for them.
REQ-027 A write whose stage-2 commit edge coincides with i_rst = 1 is discarded.
REQ-028 Requests presented while i_rst = 1 are ignored.
REQ-029 Memory contents are not cleared by reset; they are undefined at power-up.

Structure
REQ-030 Shared package bus_pkg holds BUS_AW = 32, BUS_DW = 32 and the address-window mask function.
REQ-031 One sub-module bus_ram_core: single-port, read-first, synchronous RAM (depth 2^ADDRBITS, width BUS_DW) that infers block RAM with no reset on the array.
REQ-032 Delay stages are implemented as a parametrised shift of {ack, data}; no combinational path from inputs to outputs.

Verification
REQ-033 Write 32'hDEADBEEF to F0000005 at cycle 0, read F0000005 at cycle 1 -> ack in cycle 5, o_data = DEADBEEF (LATENCY = 4).
REQ-034 Ten consecutive reads of F0000000..F0000009 after prefill with index values -> ten contiguous acks, cycles 4..13, data 0..9 in order.
REQ-035 Read 12345678 and F0004000 (ADDRBITS = 14) -> no ack; read F0003FFF -> ack with the prefilled value.
REQ-036 Simultaneous we/re at F0000002 (old 32'h11, new 32'h22) -> single ack, o_data = 32'h11; next read returns 32'h22.
REQ-037 Issue reads at cycles 0..2, assert i_rst in cycle 2 -> no acks at all; a write issued in cycle 1 is not committed.
REQ-038 LATENCY = 7, ACK_WRITES = 1: write at cycle 0 -> o_ack in cycle 7 with o_data = 0; read at cycle 1 -> ack in cycle 8 with the written data.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bus_pkg
//  Purpose  : Shared bus widths and address-window helpers for bus slaves.
//  Contents : BUS_AW / BUS_DW widths, window_mask(), addr_hit().
//  Revision : 1.0 - initial release
// ============================================================================
package bus_pkg;

  localparam int BUS_AW = 32;
  localparam int BUS_DW = 32;

  // Mask that keeps only the address bits above the slave's word index.
  function automatic logic [BUS_AW-1:0] window_mask(input int abits);
    logic [BUS_AW-1:0] lo;
    lo = '0;
    for (int i = 0; i < BUS_AW; i++) begin
      if (i < abits) lo[i] = 1'b1;
    end
    return ~lo;
  endfunction

  // Chip select: upper address bits must match the window base exactly.
  function automatic logic addr_hit(input logic [BUS_AW-1:0] addr,
                                    input logic [BUS_AW-1:0] base,
                                    input int                abits);
    return (addr & window_mask(abits)) == base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_ram_core.sv
`default_nettype none
// ============================================================================
//  Module   : bus_ram_core
//  Purpose  : Single-port, read-first synchronous RAM (block-RAM template).
//  Ports    : i_clk   - clock
//             i_en    - port enable (read always happens when enabled)
//             i_we    - write enable (qualified by i_en)
//             i_addr  - word index
//             i_wdata - write data
//             o_rdata - registered read data (pre-write word on a write)
//  Revision : 1.0 - initial release
// ============================================================================
module bus_ram_core
  import bus_pkg::*;
#(
  parameter int ADDRBITS = 14
) (
  input  logic                i_clk,
  input  logic                i_en,
  input  logic                i_we,
  input  logic [ADDRBITS-1:0] i_addr,
  input  logic [BUS_DW-1:0]   i_wdata,
  output logic [BUS_DW-1:0]   o_rdata
);

  localparam int DEPTH = 2 ** ADDRBITS;

  // No reset on the array so it maps onto block RAM.
  logic [BUS_DW-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      o_rdata <= r_mem[i_addr];
      if (i_we) r_mem[i_addr] <= i_wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_ram.sv
`default_nettype none
// ============================================================================
//  Module   : bus_ram
//  Purpose  : Fully pipelined bus-slave RAM with fixed read latency.
//  Ports    : i_clk  - clock (rising edge)
//             i_rst  - synchronous active-high reset
//             i_addr - word address of the request
//             i_we   - write strobe        i_data - write data
//             i_re   - read strobe
//             o_data - read data (zero unless o_ack)
//             o_ack  - one-cycle response strobe, LATENCY cycles after request
//  Revision : 1.0 - initial release
// ============================================================================
module bus_ram
  import bus_pkg::*;
#(
  parameter logic [BUS_AW-1:0] ADDRVAL    = 32'hF000_0000,
  parameter int                ADDRBITS   = 14,
  parameter int                LATENCY    = 4,
  parameter int                ACK_WRITES = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BUS_AW-1:0] i_addr,
  input  logic              i_we,
  input  logic [BUS_DW-1:0] i_data,
  input  logic              i_re,
  output logic [BUS_DW-1:0] o_data,
  output logic              o_ack
);

  // Stage 1 and the RAM access stage account for two cycles of latency.
  localparam int   DLY  = LATENCY - 2;
  localparam logic ACKW = (ACK_WRITES != 0);

  logic                w_hit;
  logic [ADDRBITS-1:0] r_s1_addr;
  logic [BUS_DW-1:0]   r_s1_data;
  logic                r_s1_we;
  logic                r_s1_re;
  logic                r_s1_hit;
  logic                w_ram_en;
  logic                w_ram_we;
  logic [BUS_DW-1:0]   w_ram_q;
  logic                r_s2_ack;
  logic                r_s2_rd;
  logic [BUS_DW-1:0]   w_s2_data;
  logic                r_ack_sr  [DLY];
  logic [BUS_DW-1:0]   r_data_sr [DLY];

  assign w_hit = addr_hit(i_addr, ADDRVAL, ADDRBITS);

  // Stage 1: capture the request. Address/data need no reset because every
  // downstream use is qualified by the reset-cleared strobes.
  always_ff @(posedge i_clk) begin
    r_s1_addr <= i_addr[ADDRBITS-1:0];
    r_s1_data <= i_data;
    if (i_rst) begin
      r_s1_we  <= 1'b0;
      r_s1_re  <= 1'b0;
      r_s1_hit <= 1'b0;
    end else begin
      r_s1_we  <= i_we;
      r_s1_re  <= i_re;
      r_s1_hit <= w_hit;
    end
  end

  // Stage 2: RAM access. A write whose commit edge sees reset is dropped.
  assign w_ram_en = r_s1_hit & (r_s1_we | r_s1_re);
  assign w_ram_we = r_s1_hit & r_s1_we & ~i_rst;

  bus_ram_core #(
    .ADDRBITS (ADDRBITS)
  ) u_core (
    .i_clk   (i_clk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (r_s1_addr),
    .i_wdata (r_s1_data),
    .o_rdata (w_ram_q)
  );

  // Response flags travel alongside the RAM output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s2_ack <= 1'b0;
      r_s2_rd  <= 1'b0;
    end else begin
      r_s2_ack <= r_s1_hit & (r_s1_re | (ACKW & r_s1_we));
      r_s2_rd  <= r_s1_hit & r_s1_re;
    end
  end

  // Write-only acks return zero data; idle slots carry zero as well.
  assign w_s2_data = r_s2_rd ? w_ram_q : '0;

  // Pure delay of {ack, data}; the last stage drives the outputs directly.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DLY; i++) begin
        r_ack_sr[i]  <= 1'b0;
        r_data_sr[i] <= '0;
      end
    end else begin
      r_ack_sr[0]  <= r_s2_ack;
      r_data_sr[0] <= w_s2_data;
      for (int i = 1; i < DLY; i++) begin
        r_ack_sr[i]  <= r_ack_sr[i-1];
        r_data_sr[i] <= r_data_sr[i-1];
      end
    end
  end

  assign o_ack  = r_ack_sr[DLY-1];
  assign o_data = r_data_sr[DLY-1];

endmodule
`default_nettype wire

// File: tb/tb_bus_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_ram
//  Purpose  : Self-checking bench for bus_ram. Two instances share stimulus:
//             dut  (ADDRBITS 14, LATENCY 4, no write acks) and
//             dut7 (ADDRBITS 6,  LATENCY 7, write acks).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_ram;

  localparam logic [31:0] BASE = 32'hF000_0000;
  localparam int          NCYC = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        we;
  logic        re;
  logic [31:0] wdata;
  logic [31:0] d0_data, d1_data;
  logic        d0_ack, d1_ack;

  always #5 clk = ~clk;

  bus_ram #(.ADDRVAL(BASE), .ADDRBITS(14), .LATENCY(4), .ACK_WRITES(0)) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_we(we), .i_data(wdata),
    .i_re(re), .o_data(d0_data), .o_ack(d0_ack));

  bus_ram #(.ADDRVAL(BASE), .ADDRBITS(6), .LATENCY(7), .ACK_WRITES(1)) dut7 (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_we(we), .i_data(wdata),
    .i_re(re), .o_data(d1_data), .o_ack(d1_ack));

  // ---------------- reference model (per instance m = 0 / 1) ----------------
  int lat   [2] = '{4, 7};
  int abits [2] = '{14, 6};
  bit ackw  [2] = '{1'b0, 1'b1};

  bit          exp_ack  [2][NCYC];
  logic [31:0] exp_data [2][NCYC];
  bit          exp_dc   [2][NCYC];
  bit          act_ack  [2][NCYC];
  logic [31:0] act_data [2][NCYC];
  logic [31:0] mmem     [2][16384];
  bit          mknown   [2][16384];

  typedef struct {
    int          m;
    int          n;
    int          idx;
    logic [31:0] old;
    bit          oldk;
  } wr_t;
  wr_t pend[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  initial begin
    for (int m = 0; m < 2; m++)
      for (int c = 0; c < NCYC; c++) begin
        exp_ack[m][c]  = 1'b0;
        exp_data[m][c] = 32'd0;
        exp_dc[m][c]   = 1'b0;
      end
  end

  // Requests are processed in issue order: a read sees every earlier write,
  // never its own; the response is due exactly lat cycles later.
  task automatic model_req(input int m, input logic [31:0] a, input bit w,
                           input bit r, input logic [31:0] d);
    longint off, span;
    int     idx, t;
    wr_t    e;
    off  = longint'({32'd0, a}) - longint'({32'd0, BASE});
    span = 1;
    span = span << abits[m];
    if (off < 0 || off >= span || !(w || r)) return;
    idx = int'(off);
    t   = cyc + lat[m];
    if (r) begin
      exp_ack[m][t] = 1'b1;
      if (mknown[m][idx]) exp_data[m][t] = mmem[m][idx];
      else                exp_dc[m][t]   = 1'b1;
    end else if (ackw[m]) begin
      exp_ack[m][t]  = 1'b1;
      exp_data[m][t] = 32'd0;
    end
    if (w) begin
      e.m = m; e.n = cyc; e.idx = idx; e.old = mmem[m][idx]; e.oldk = mknown[m][idx];
      pend.push_back(e);
      mmem[m][idx]   = d;
      mknown[m][idx] = 1'b1;
    end
  endtask

  // Reset in cycle r: everything still in flight is dropped, and a write
  // whose commit edge is the reset edge (issued in r-1) never lands.
  task automatic model_reset(input int r);
    for (int m = 0; m < 2; m++)
      for (int c = r + 1; c <= r + lat[m]; c++) begin
        exp_ack[m][c]  = 1'b0;
        exp_data[m][c] = 32'd0;
        exp_dc[m][c]   = 1'b0;
      end
    for (int i = pend.size() - 1; i >= 0; i--)
      if (pend[i].n >= r - 1) begin
        mmem[pend[i].m][pend[i].idx]   = pend[i].old;
        mknown[pend[i].m][pend[i].idx] = pend[i].oldk;
      end
    pend.delete();
  endtask

  // One bus cycle: drive, model, advance to the next cycle, go idle.
  task automatic step(input logic [31:0] a, input bit w, input bit r,
                      input logic [31:0] d, input bit rs);
    addr = a; we = w; re = r; wdata = d; rst = rs;
    if (rs) model_reset(cyc);
    else begin
      model_req(0, a, w, r, d);
      model_req(1, a, w, r, d);
    end
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0; we = 1'b0; re = 1'b0; addr = 32'd0; wdata = 32'd0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Per-cycle monitor: log outputs and compare against the model.
  always @(negedge clk) begin
    if (cyc < NCYC) begin
      act_ack[0][cyc]  = d0_ack;  act_data[0][cyc] = d0_data;
      act_ack[1][cyc]  = d1_ack;  act_data[1][cyc] = d1_data;
      if (chk_en) begin
        for (int m = 0; m < 2; m++) begin
          checks++;
          if (act_ack[m][cyc] !== exp_ack[m][cyc] ||
              (!exp_dc[m][cyc] && act_data[m][cyc] !== exp_data[m][cyc])) begin
            errors++;
            $display("FAIL model%0d cycle %0d: got ack=%0b data=%h, want ack=%0b data=%h",
                     m, cyc, act_ack[m][cyc], act_data[m][cyc],
                     exp_ack[m][cyc], exp_data[m][cyc]);
          end
        end
      end
    end
  end

  // ---------------- directed vectors for the LATENCY-4 instance ------------
  typedef struct {
    logic [31:0] a;
    bit          w;
    bit          r;
    logic [31:0] d;
    bit          eack;
    logic [31:0] edata;
  } vec_t;
  vec_t vt[13];

  initial begin
    int n, k, sel, op;
    logic [31:0] a;

    vt[0]  = '{BASE + 32'h5,    1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1]  = '{BASE + 32'h5,    1'b0, 1'b1, 32'h0,        1'b1, 32'hDEADBEEF};
    vt[2]  = '{32'h12345678,    1'b0, 1'b1, 32'h0,        1'b0, 32'h0};
    vt[3]  = '{32'hF0004000,    1'b0, 1'b1, 32'h0,        1'b0, 32'h0};
    vt[4]  = '{32'hF0003FFF,    1'b0, 1'b1, 32'h0,        1'b1, 32'hCAFE3FFF};
    vt[5]  = '{32'hEFFFFFFF,    1'b0, 1'b1, 32'h0,        1'b0, 32'h0};
    vt[6]  = '{BASE + 32'h2,    1'b1, 1'b0, 32'h11,       1'b0, 32'h0};
    vt[7]  = '{BASE + 32'h2,    1'b1, 1'b1, 32'h22,       1'b1, 32'h11};
    vt[8]  = '{BASE + 32'h2,    1'b0, 1'b1, 32'h0,        1'b1, 32'h22};
    vt[9]  = '{BASE + 32'h9,    1'b0, 1'b1, 32'h0,        1'b1, 32'h9};
    vt[10] = '{BASE + 32'h9,    1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    vt[11] = '{32'hF0003FFF,    1'b1, 1'b0, 32'hA5A5A5A5, 1'b0, 32'h0};
    vt[12] = '{32'hF0003FFF,    1'b0, 1'b1, 32'h0,        1'b1, 32'hA5A5A5A5};

    rst = 1'b1; addr = 32'd0; we = 1'b0; re = 1'b0; wdata = 32'd0;
    step(32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    chk_en = 1'b1;
    step(32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    step(32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
    idle(2);
    chk("reset ack", {31'd0, act_ack[0][2]}, 32'd0);
    chk("reset data", act_data[0][2], 32'd0);

    // Prefill with index values, plus the last word of the big window.
    for (int i = 0; i < 64; i++) step(BASE + i, 1'b1, 1'b0, i, 1'b0);
    step(32'hF0003FFF, 1'b1, 1'b0, 32'hCAFE3FFF, 1'b0);
    idle(10);

    for (int i = 0; i < 13; i++) begin
      n = cyc;
      step(vt[i].a, vt[i].w, vt[i].r, vt[i].d, 1'b0);
      idle(6);
      chk($sformatf("vec%0d ack", i), {31'd0, act_ack[0][n+4]}, {31'd0, vt[i].eack});
      chk($sformatf("vec%0d data", i), act_data[0][n+4], vt[i].edata);
      chk($sformatf("vec%0d no early ack", i), {31'd0, act_ack[0][n+3]}, 32'd0);
      chk($sformatf("vec%0d no late ack", i), {31'd0, act_ack[0][n+5]}, 32'd0);
    end

    // Write then read the same word back to back; also the write ack of dut7.
    n = cyc;
    step(BASE + 32'h5, 1'b1, 1'b0, 32'h0BADF00D, 1'b0);
    step(BASE + 32'h5, 1'b0, 1'b1, 32'h0, 1'b0);
    idle(10);
    chk("b2b write no ack", {31'd0, act_ack[0][n+4]}, 32'd0);
    chk("b2b read ack", {31'd0, act_ack[0][n+5]}, 32'd1);
    chk("b2b read data", act_data[0][n+5], 32'h0BADF00D);
    chk("lat7 write ack", {31'd0, act_ack[1][n+7]}, 32'd1);
    chk("lat7 write data", act_data[1][n+7], 32'd0);
    chk("lat7 read ack", {31'd0, act_ack[1][n+8]}, 32'd1);
    chk("lat7 read data", act_data[1][n+8], 32'h0BADF00D);
    chk("lat7 no early ack", {31'd0, act_ack[1][n+6]}, 32'd0);

    // Ten consecutive reads after restoring index values.
    for (int i = 0; i < 10; i++) step(BASE + i, 1'b1, 1'b0, i, 1'b0);
    n = cyc;
    for (int i = 0; i < 10; i++) step(BASE + i, 1'b0, 1'b1, 32'h0, 1'b0);
    idle(8);
    chk("burst no early ack", {31'd0, act_ack[0][n+3]}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("burst%0d ack", i), {31'd0, act_ack[0][n+4+i]}, 32'd1);
      chk($sformatf("burst%0d data", i), act_data[0][n+4+i], i);
    end
    chk("burst no trailing ack", {31'd0, act_ack[0][n+14]}, 32'd0);

    // Reset in the third of three requests: nothing acked, write dropped.
    n = cyc;
    step(BASE + 32'h1, 1'b0, 1'b1, 32'h0, 1'b0);
    step(BASE + 32'h7, 1'b1, 1'b1, 32'h77, 1'b0);
    step(BASE + 32'h3, 1'b0, 1'b1, 32'h0, 1'b1);
    idle(12);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("reset drop ack c%0d", c), {31'd0, act_ack[0][n+c]}, 32'd0);
      chk($sformatf("reset drop ack7 c%0d", c), {31'd0, act_ack[1][n+c]}, 32'd0);
    end
    n = cyc;
    step(BASE + 32'h7, 1'b0, 1'b1, 32'h0, 1'b0);
    idle(6);
    chk("dropped write ack", {31'd0, act_ack[0][n+4]}, 32'd1);
    chk("dropped write data", act_data[0][n+4], 32'h7);

    // Randomised traffic, checked cycle by cycle against the model.
    for (k = 0; k < 500; k++) begin
      sel = $urandom_range(0, 9);
      op  = $urandom_range(0, 3);
      if (sel <= 6)      a = BASE + $urandom_range(0, 63);
      else if (sel == 7) a = 32'hF0003FF0 + $urandom_range(0, 31);
      else if (sel == 8) a = $urandom;
      else               a = BASE - 32'd1 - $urandom_range(0, 3);
      step(a, (op == 2) || (op == 3), (op == 1) || (op == 3), $urandom,
           ($urandom_range(0, 99) < 2));
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
